// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame width and line idle level.
// Also consumed by the receive side.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/module_uart_tx_if.sv
// FIFO first-word-fall-through read port seen by a consumer (master) and the FIFO (slave).
// The head word is valid whenever fifo_empty is low; fifo_re pops it at the clock edge.
interface module_uart_tx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);

  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_re;

  modport master (input fifo_empty, input fifo_dout, output fifo_re);
  modport slave  (output fifo_empty, output fifo_dout, input fifo_re);

endinterface

// File: rtl/module_baud_counter.sv
// Bit-period timer: tick is high for one cycle every max(div,1) cycles after load.
// div is captured on load, so later changes to the input do not affect the running period.
module module_baud_counter #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_reload;
  logic [DIV_WIDTH-1:0] w_reload;

  // A divisor of zero behaves like one: reload value 0 ticks every cycle.
  assign w_reload = (div == '0) ? '0 : (div - ONE);
  assign tick     = (r_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_reload <= '0;
    end else if (load) begin
      r_cnt    <= w_reload;
      r_reload <= w_reload;
    end else if (r_cnt == '0) begin
      r_cnt <= r_reload;
    end else begin
      r_cnt <= r_cnt - ONE;
    end
  end

endmodule

// File: rtl/module_uart_tx.sv
// UART transmitter draining a FWFT FIFO: start bit, 8 data bits LSB-first, optional parity, 1/2 stop bits.
// Pops only from IDLE when enabled and non-empty; txd goes low the cycle after the pop.
module module_uart_tx
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DIV_WIDTH-1:0]   baud_div,
  input  logic                   parity_en,
  input  logic                   parity_odd,
  input  logic                   stop2,
  module_uart_tx_if.master       fifo,
  output logic                   txd,
  output logic                   busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_tx_state_t       r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_bit_idx;
  logic                 r_stop_cnt;
  logic                 r_par_en;
  logic                 r_par_bit;
  logic                 r_stop2;
  logic                 r_txd;
  logic                 r_busy;
  logic                 w_pop;
  logic                 w_tick;

  // Gated by reset so the FIFO never loses a word while the transmitter is held.
  assign w_pop        = ~reset & (r_state == IDLE) & enable & ~fifo.fifo_empty;
  assign fifo.fifo_re = w_pop;
  assign txd          = r_txd;
  assign busy         = r_busy;

  module_baud_counter #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .load  (w_pop),
    .div   (baud_div),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_txd      <= UART_IDLE_LEVEL;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift    <= fifo.fifo_dout;
            r_par_en   <= parity_en;
            r_par_bit  <= (^fifo.fifo_dout) ^ parity_odd;
            r_stop2    <= stop2;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_txd      <= ~UART_IDLE_LEVEL;
            r_busy     <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_txd   <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_BIT) begin
              r_txd   <= r_par_en ? r_par_bit : UART_IDLE_LEVEL;
              r_state <= r_par_en ? PARITY : STOP;
            end else begin
              r_txd     <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        PARITY: begin
          if (w_tick) begin
            r_txd   <= UART_IDLE_LEVEL;
            r_state <= STOP;
          end
        end
        STOP: begin
          // With two stop bits the first tick only advances the stop counter.
          if (w_tick) begin
            if (r_stop2 && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
